siso_shift_ctrl: RTL and testbench
==================================

// Module: siso_shift_ctrl
// PURPOSE
//  Sequencer for an external enable-gated SISO shift chain used as a serial delay line.
//  Accepts a parallel word on a valid/ready port and serialises it into the chain.
//  Flushes the chain with zeros, deserialises the emerging bits and returns the word on a valid/ready port.
//  Sits between a parallel producer/consumer and the serial chain; one frame in flight at a time.
// PARAMETERS
//  DATA_W      8  frame width in bits (>=1)
//  CHAIN_DEPTH 4  stages in the attached chain (>=1); must equal the chain's real depth
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            reset, asynchronous, active-high
//  in_valid   in   1            producer has a frame on in_data
//  in_ready   out  1            controller can accept a frame (high only in IDLE)
//  in_data    in   DATA_W       parallel frame to serialise
//  out_valid  out  1            deserialised frame available on out_data
//  out_ready  in   1            consumer accepts out_data
//  out_data   out  DATA_W       deserialised frame, registered
//  busy       out  1            high in SHIFT, FLUSH and HOLD
//  sr_shift   out  1            shift enable to chain; chain shifts on clk edge when high
//  sr_din     out  1            serial bit into chain, meaningful when sr_shift=1
//  sr_dout    in   1            chain output (last stage)
// BEHAVIOUR
//  Reset values: state=IDLE, cnt=0, in_ready=1, out_valid=0, out_data=0, busy=0, sr_shift=0, sr_din=0.
//  The chain shares rst, so it is all-zero after reset; every frame leaves the chain all-zero.
//  States:
//   IDLE  -> SHIFT on in_valid&in_ready; in_data latched to tx_reg; cnt<=0.
//   SHIFT -> sr_shift=1, sr_din=tx bit for index cnt; moves to FLUSH when cnt==DATA_W-1.
//   FLUSH -> sr_shift=1, sr_din=0; moves to HOLD when cnt==DATA_W+CHAIN_DEPTH-1.
//   HOLD  -> out_valid=1; out_data held stable; moves to IDLE on out_ready (out_valid drops next cycle).
//  Counter: cnt increments on every cycle with sr_shift=1 and spans 0..DATA_W+CHAIN_DEPTH-1.
//   cnt width is $clog2(DATA_W+CHAIN_DEPTH).
//  Capture:
//   On each shift edge with cnt>=CHAIN_DEPTH, sr_dout (bit inserted at shift cnt-CHAIN_DEPTH) is stored.
//   It goes to rx bit index cnt-CHAIN_DEPTH, using the same ordering as transmit.
//   Captures when cnt<CHAIN_DEPTH are discarded (zeros).
//  Latency:
//   Accept edge E0; shifts occur in cycles E0+1..E0+DATA_W+CHAIN_DEPTH.
//   out_valid rises at E0+DATA_W+CHAIN_DEPTH+1.
//   in_ready returns 1 the cycle after the out handshake.
//   Back-to-back throughput: 1 frame per DATA_W+CHAIN_DEPTH+2 cycles.
//  Boundaries:
//   in_valid during busy is ignored (in_ready=0); producer must hold its data.
//   out_ready held high at HOLD entry -> handshake completes in the first HOLD cycle.
//   out_valid never drops without out_ready.
//   DATA_W=1 -> SHIFT lasts exactly one cycle.
//   rst asserted mid-frame -> IDLE immediately and the frame is lost; the chain also clears.
// CONFIGURATION
//  SISO_SHIFT_CTRL_LSB_FIRST_EN
//   Defined: transmit index cnt uses tx_reg[cnt]; capture fills rx[cnt-CHAIN_DEPTH] (LSB first).
//   Undefined (default): MSB first; tx_reg[DATA_W-1-cnt] and rx[DATA_W-1-(cnt-CHAIN_DEPTH)].
//  out_data==in_data in both modes; only the sr_din bit sequence differs.
// STRUCTURE
//  Package siso_pkg:
//   typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, HOLD} siso_ctrl_state_t;
//   function cnt_w(DATA_W, CHAIN_DEPTH).
//  RTL is one module: FSM, counter, tx/rx registers inline.
//  Natural sub-module: siso_shift_chain (CHAIN_DEPTH stages, shift-enable gated, async rst).
//   It is the chain this block drives; the bench instantiates it beside the DUT.
// TESTING (DATA_W=8, CHAIN_DEPTH=4, chain attached)
//  1 Reset, then idle 5 cycles -> in_ready=1, busy=0, sr_shift=0, out_valid=0.
//  2 Send 8'hA5, out_ready=1 -> sr_shift high 12 cycles; sr_din=1,0,1,0,0,1,0,1,0,0,0,0;
//    out_valid at accept+13 with out_data=8'hA5.
//  3 Send 8'h3C, hold out_ready=0 for 10 cycles -> out_valid/out_data stable throughout;
//    IDLE one cycle after out_ready.
//  4 Frames 8'hFF then 8'h00 back-to-back -> second out_data=8'h00 (flush left the chain clean);
//    in_valid during busy is not accepted.
//  5 Assert rst at SHIFT cnt=3 -> all outputs at reset values; next frame 8'h81 returns 8'h81.
//  6 With SISO_SHIFT_CTRL_LSB_FIRST_EN, send 8'h01 -> sr_din first bit=1;
//    out_data=8'h01 at accept+13.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared types and helpers for the SISO shift-chain sequencer.
// Holds the controller state encoding and the counter-width helper.
package siso_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FLUSH,
        HOLD
    } siso_ctrl_state_t;

    // Counter must reach DATA_W+CHAIN_DEPTH-1 (all shifts of one frame).
    function automatic int cnt_w(input int data_w, input int chain_depth);
        return $clog2(data_w + chain_depth);
    endfunction

endpackage

// File: rtl/siso_shift_chain.sv
// Enable-gated serial-in/serial-out chain driven by siso_shift_ctrl.
// Shares the controller reset so it is empty whenever the controller is.
module siso_shift_chain #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic shift,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stages;

    // Shift one place toward the output on each enabled edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else if (shift) begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/siso_shift_ctrl.sv
// Serialises a word into an external SISO chain, flushes it, returns it.
// Define SISO_SHIFT_CTRL_LSB_FIRST_EN for LSB-first bit order (default MSB).
module siso_shift_ctrl
    import siso_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int CHAIN_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              sr_shift,
    output logic              sr_din,
    input  logic              sr_dout
);

    localparam int CW = cnt_w(DATA_W, CHAIN_DEPTH);
    localparam logic [CW-1:0] LAST_TX  = CW'(DATA_W - 1);
    localparam logic [CW-1:0] LAST_ALL = CW'(DATA_W + CHAIN_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(CHAIN_DEPTH);

    siso_ctrl_state_t  state;
    siso_ctrl_state_t  state_nxt;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] tx_reg;
    logic [DATA_W-1:0] rx_reg;
    logic              accept;
    logic              tx_bit;
    int                tx_idx;
    int                rx_idx;

    assign accept   = in_valid & in_ready;
    assign out_data = rx_reg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus handshake and chain-control outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        sr_shift  = 1'b0;
        sr_din    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sr_shift = 1'b1;
                sr_din   = tx_bit;
                if (cnt == LAST_TX) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                sr_shift = 1'b1;
                if (cnt == LAST_ALL) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bit positions for the outgoing and the returning bit
    always_comb begin
`ifdef SISO_SHIFT_CTRL_LSB_FIRST_EN
        tx_idx = int'(cnt);
        rx_idx = int'(cnt) - CHAIN_DEPTH;
`else
        tx_idx = DATA_W - 1 - int'(cnt);
        rx_idx = DATA_W - 1 - (int'(cnt) - CHAIN_DEPTH);
`endif
        tx_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == tx_idx) begin
                tx_bit = tx_reg[i];
            end
        end
    end

    // Counter, transmit latch and receive capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            tx_reg <= '0;
            rx_reg <= '0;
        end else if (accept) begin
            tx_reg <= in_data;
            cnt    <= '0;
        end else if (sr_shift) begin
            cnt <= (cnt == LAST_ALL) ? '0 : cnt + CW'(1);
            // The first CHAIN_DEPTH outputs are stale chain zeros
            if (cnt >= DEPTH_C) begin
                for (int i = 0; i < DATA_W; i++) begin
                    if (i == rx_idx) begin
                        rx_reg[i] <= sr_dout;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Scoreboard bench for siso_shift_ctrl with siso_shift_chain attached.
// Expected bit order follows SISO_SHIFT_CTRL_LSB_FIRST_EN when defined.
module tb_siso_shift_ctrl;

    localparam int DW = 8;
    localparam int CD = 4;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic          sr_shift;
    logic          sr_din;
    logic          sr_dout;
    logic [DW-1:0] out_data;

    logic [DW-1:0] sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    time           t_acc   = 0;
    time           t_prev  = 0;

    always #5 clk = ~clk;

    siso_shift_ctrl #(
        .DATA_W      (DW),
        .CHAIN_DEPTH (CD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .sr_shift  (sr_shift),
        .sr_din    (sr_din),
        .sr_dout   (sr_dout)
    );

    siso_shift_chain #(
        .DEPTH (CD)
    ) u_chain (
        .clk   (clk),
        .rst   (rst),
        .shift (sr_shift),
        .din   (sr_din),
        .dout  (sr_dout)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit the chain should see on shift k of a frame carrying d
    function automatic logic exp_bit(input logic [DW-1:0] d,
                                     input int k);
        if (k >= DW) begin
            return 1'b0;
        end
`ifdef SISO_SHIFT_CTRL_LSB_FIRST_EN
        return d[k];
`else
        return d[DW-1-k];
`endif
    endfunction

    // Called at a negedge; returns at the accept posedge, in_valid still 1
    task automatic send(input logic [DW-1:0] d);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("accept", 32'(in_ready), 32'd1);
        sb_q.push_back(d);
        @(posedge clk);
        t_acc = $time;
    endtask

    task automatic run_frame(input logic [DW-1:0] d,
                             input int hold,
                             input bit probe);
        logic [DW-1:0] exp;
        out_ready = (hold == 0);
        send(d);
        for (int k = 0; k < DW + CD; k++) begin
            @(negedge clk);
            if (probe) begin
                in_valid = 1'b1;
                in_data  = 8'h77;
                chk("busy_rdy", 32'({busy, in_ready}), 32'd2);
            end else begin
                in_valid = 1'b0;
            end
            chk("sr_shift", 32'(sr_shift), 32'd1);
            chk("sr_din", 32'(sr_din), 32'(exp_bit(d, k)));
            chk("ov_early", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("ov_lat", 32'(out_valid), 32'd1);
        chk("sr_stop", 32'(sr_shift), 32'd0);
        for (int h = 0; h < hold; h++) begin
            chk("hold_ov", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(sb_q[0]));
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("out_valid", 32'(out_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            chk("out_data", 32'(out_data), 32'(exp));
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_rdy", 32'(in_ready), 32'd1);
        chk("ov_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_shift", 32'(sr_shift), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);

        // Plain frame, consumer always ready
        run_frame(8'hA5, 0, 1'b0);

        // Consumer stalls for 10 cycles
        run_frame(8'h3C, 10, 1'b0);

        // Back-to-back, with ignored requests while busy
        run_frame(8'hFF, 0, 1'b1);
        t_prev = t_acc;
        run_frame(8'h00, 0, 1'b1);
        chk("b2b_period", 32'((t_acc - t_prev) / 10), 32'(DW + CD + 2));

        // Reset in the middle of SHIFT (cnt=3)
        out_ready = 1'b1;
        send(8'h5A);
        void'(sb_q.pop_back());
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_shift", 32'(sr_shift), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_rdy", 32'(in_ready), 32'd1);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_shift", 32'(sr_shift), 32'd0);
        chk("mr_din", 32'(sr_din), 32'd0);
        chk("mr_ov", 32'(out_valid), 32'd0);
        chk("mr_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(8'h81, 0, 1'b0);

        // Single set LSB: first serial bit differs by build order
        run_frame(8'h01, 0, 1'b0);
        run_frame(8'hC3, 3, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
